// File: rtl/resize_frame_ctrl_pkg.sv
// rtl/resize_frame_ctrl_pkg.sv - shared constants and state encoding for the resize frame controller
package resize_frame_ctrl_pkg;

    localparam int DEF_NUM_BINS       = 784;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;

    localparam int WR_CNT_W = 11;

    // status_err bit positions
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_RANGE   = 1;
    localparam int ERR_SHORT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_FILL,
        ST_READY,
        ST_ERR
    } state_t;

endpackage

// File: rtl/resize_frame_ctrl_if.sv
// rtl/resize_frame_ctrl_if.sv - resizer, consumer and bin SRAM signals of the frame controller
interface resize_frame_ctrl_if #(
    parameter int DATA_W = resize_frame_ctrl_pkg::DEF_DATA_W
) ();
    logic              rs_start_bin;
    logic              rs_bin_done;
    logic [31:0]       rs_addr;
    logic [DATA_W-1:0] rs_wdata;
    logic              rs_wr_en;

    logic              cons_req;
    logic [31:0]       cons_addr;
    logic              cons_gnt;
    logic [DATA_W-1:0] cons_rdata;
    logic              cons_rvalid;
    logic              cons_release;
    logic              frame_ready;

    logic [31:0]       sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic [DATA_W-1:0] sram_rdata;

    // controller side
    modport master (
        output rs_start_bin,
        input  rs_bin_done, rs_addr, rs_wdata, rs_wr_en,
        input  cons_req, cons_addr, cons_release,
        output cons_gnt, cons_rdata, cons_rvalid, frame_ready,
        output sram_addr, sram_wdata, sram_we,
        input  sram_rdata
    );

    // resizer / consumer / SRAM side
    modport slave (
        input  rs_start_bin,
        output rs_bin_done, rs_addr, rs_wdata, rs_wr_en,
        output cons_req, cons_addr, cons_release,
        input  cons_gnt, cons_rdata, cons_rvalid, frame_ready,
        input  sram_addr, sram_wdata, sram_we,
        output sram_rdata
    );
endinterface

// File: rtl/resize_frame_ctrl_bin_port_mux.sv
// rtl/resize_frame_ctrl_bin_port_mux.sv - combinational bin SRAM owner mux with address range checks
module resize_frame_ctrl_bin_port_mux #(
    parameter int NUM_BINS = 784,
    parameter int DATA_W   = 32
) (
    input  logic              rs_own,
    input  logic              cons_own,
    input  logic [31:0]       rs_addr,
    input  logic [DATA_W-1:0] rs_wdata,
    input  logic              rs_wr_en,
    input  logic              cons_req,
    input  logic [31:0]       cons_addr,
    output logic [31:0]       sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              cons_gnt,
    output logic              cons_oor,
    output logic              rs_accept,
    output logic              rs_bad
);
    localparam logic [31:0] BIN_LIMIT = 32'(NUM_BINS);

    logic rs_in_range;
    logic cons_in_range;

    assign rs_in_range   = (rs_addr < BIN_LIMIT);
    assign cons_in_range = (cons_addr < BIN_LIMIT);

    // Port goes to whichever side owns it; with no owner everything is parked at zero.
    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_we    = 1'b0;
        cons_gnt   = 1'b0;
        cons_oor   = 1'b0;
        if (rs_own) begin
            sram_addr  = rs_addr;
            sram_wdata = rs_wdata;
            sram_we    = rs_wr_en && rs_in_range;
        end else if (cons_own) begin
            sram_addr = cons_addr;
            cons_gnt  = cons_req;
            cons_oor  = cons_req && !cons_in_range;
        end
        rs_accept = rs_own && rs_wr_en && rs_in_range;
        rs_bad    = rs_wr_en && !(rs_own && rs_in_range);
    end
endmodule

// File: rtl/resize_frame_ctrl.sv
// rtl/resize_frame_ctrl.sv - frame sequencer and bin SRAM arbiter for the 28x28 resizer
module resize_frame_ctrl
    import resize_frame_ctrl_pkg::*;
#(
    parameter int NUM_BINS       = DEF_NUM_BINS,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic        cmd_continuous,
    output logic        status_busy,
    output logic        status_done,
    output logic [2:0]  status_err,
    output logic [15:0] frame_count,
    resize_frame_ctrl_if.master bus
);
    state_t              state;
    logic [WR_CNT_W-1:0] wr_cnt;
    logic [31:0]         tmo_cnt;
    logic                rvalid_q;
    logic                rd_oor_q;

    logic cons_gnt;
    logic cons_oor;
    logic rs_accept;
    logic rs_bad;

    resize_frame_ctrl_bin_port_mux #(
        .NUM_BINS (NUM_BINS),
        .DATA_W   (DATA_W)
    ) u_mux (
        .rs_own     (state == ST_FILL),
        .cons_own   (state == ST_READY),
        .rs_addr    (bus.rs_addr),
        .rs_wdata   (bus.rs_wdata),
        .rs_wr_en   (bus.rs_wr_en),
        .cons_req   (bus.cons_req),
        .cons_addr  (bus.cons_addr),
        .sram_addr  (bus.sram_addr),
        .sram_wdata (bus.sram_wdata),
        .sram_we    (bus.sram_we),
        .cons_gnt   (cons_gnt),
        .cons_oor   (cons_oor),
        .rs_accept  (rs_accept),
        .rs_bad     (rs_bad)
    );

    assign bus.cons_gnt     = cons_gnt;
    assign bus.rs_start_bin = (state == ST_KICK);
    assign bus.frame_ready  = (state == ST_READY);
    assign status_busy      = (state == ST_KICK) || (state == ST_FILL);
    assign bus.cons_rvalid  = rvalid_q;
    assign bus.cons_rdata   = (rvalid_q && !rd_oor_q) ? bus.sram_rdata : '0;

    // Frame sequencer: state, sticky status, frame and write counters, FILL watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            status_done <= 1'b0;
            status_err  <= '0;
            frame_count <= '0;
            wr_cnt      <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state       <= ST_KICK;
                        status_done <= 1'b0;
                        status_err  <= '0;
                        wr_cnt      <= '0;
                    end
                end
                ST_KICK: begin
                    tmo_cnt <= '0;
                    wr_cnt  <= '0;
                    if (cmd_abort) begin
                        state       <= ST_IDLE;
                        status_done <= 1'b0;
                    end else begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (rs_accept) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    if (cmd_abort) begin
                        state       <= ST_IDLE;
                        status_done <= 1'b0;
                    end else if (bus.rs_bin_done) begin
                        state       <= ST_READY;
                        status_done <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        if (wr_cnt != WR_CNT_W'(NUM_BINS)) begin
                            status_err[ERR_SHORT] <= 1'b1;
                        end
                    end else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state                   <= ST_ERR;
                        status_err[ERR_TIMEOUT] <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                ST_READY: begin
                    if (cmd_abort) begin
                        state       <= ST_IDLE;
                        status_done <= 1'b0;
                    end else if (bus.cons_release) begin
                        state <= cmd_continuous ? ST_KICK : ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (cmd_abort) begin
                        state       <= ST_IDLE;
                        status_done <= 1'b0;
                    end else if (cmd_start) begin
                        state       <= ST_KICK;
                        status_done <= 1'b0;
                        status_err  <= '0;
                        wr_cnt      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (rs_bad) begin
                status_err[ERR_RANGE] <= 1'b1;
            end
        end
    end

    // Read return pipeline: rvalid one cycle after grant, out-of-range reads return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            rvalid_q <= cons_gnt;
            rd_oor_q <= cons_oor;
        end
    end
endmodule

// File: tb/tb_resize_frame_ctrl.sv
// tb/tb_resize_frame_ctrl.sv - self-checking randomized bench for resize_frame_ctrl
module tb_resize_frame_ctrl;
    import resize_frame_ctrl_pkg::*;

    localparam int NB = DEF_NUM_BINS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cmd_start, cmd_abort, cmd_continuous;
    logic        status_busy, status_done;
    logic [2:0]  status_err;
    logic [15:0] frame_count;

    logic        t_start, t_abort;
    logic        t_busy, t_done;
    logic [2:0]  t_err;
    logic [15:0] t_fc;

    resize_frame_ctrl_if #(.DATA_W(32)) bus ();
    resize_frame_ctrl_if #(.DATA_W(32)) t_bus ();

    resize_frame_ctrl #(.NUM_BINS(NB), .DATA_W(32), .TIMEOUT_CYCLES(4096)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cmd_continuous (cmd_continuous),
        .status_busy    (status_busy),
        .status_done    (status_done),
        .status_err     (status_err),
        .frame_count    (frame_count),
        .bus            (bus)
    );

    resize_frame_ctrl #(.NUM_BINS(NB), .DATA_W(32), .TIMEOUT_CYCLES(64)) dut_tmo (
        .clk            (clk),
        .reset          (reset),
        .cmd_start      (t_start),
        .cmd_abort      (t_abort),
        .cmd_continuous (1'b0),
        .status_busy    (t_busy),
        .status_done    (t_done),
        .status_err     (t_err),
        .frame_count    (t_fc),
        .bus            (t_bus)
    );

    // Single-port SRAM with one cycle read latency, never cleared by reset.
    logic [31:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (bus.sram_we) sram_mem[bus.sram_addr[9:0]] <= bus.sram_wdata;
        bus.sram_rdata <= sram_mem[bus.sram_addr[9:0]];
    end

    // Expected picture of the bin SRAM and expected frame counter.
    logic [31:0] ref_mem [0:NB-1];
    int          exp_fc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_start        = 1'b0;
        cmd_abort        = 1'b0;
        bus.rs_bin_done  = 1'b0;
        bus.rs_wr_en     = 1'b0;
        bus.rs_addr      = '0;
        bus.rs_wdata     = '0;
        bus.cons_req     = 1'b0;
        bus.cons_addr    = '0;
        bus.cons_release = 1'b0;
    endtask

    task automatic start_frame();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("kick_pulse", bus.rs_start_bin, 1);
        check("kick_busy", status_busy, 1);
        check("kick_err_clr", status_err, 0);
        check("kick_done_clr", status_done, 0);
        tick();
        check("fill_pulse_gone", bus.rs_start_bin, 0);
    endtask

    // Writes every bin once in random order, optionally skipping one and adding one stray write.
    task automatic fill(input int skip_addr, input bit stray);
        int perm [NB];
        int stray_pos;
        for (int i = 0; i < NB; i++) perm[i] = i;
        for (int i = NB - 1; i > 0; i--) begin
            int j = $urandom_range(i);
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        stray_pos = $urandom_range(NB - 1);
        for (int i = 0; i < NB; i++) begin
            if ($urandom_range(7) == 0) begin
                bus.rs_wr_en = 1'b0;
                bus.cons_req = 1'b1;
                bus.cons_addr = 32'($urandom_range(NB - 1));
                #1;
                check("fill_no_gnt", bus.cons_gnt, 0);
                tick();
                bus.cons_req = 1'b0;
            end
            if (stray && i == stray_pos) begin
                bus.rs_wr_en = 1'b1;
                bus.rs_addr  = 32'(NB + 16);
                bus.rs_wdata = $urandom;
                #1;
                check("oor_we_low", bus.sram_we, 0);
                tick();
            end
            if (perm[i] != skip_addr) begin
                bus.rs_wr_en = 1'b1;
                bus.rs_addr  = 32'(perm[i]);
                bus.rs_wdata = $urandom;
                ref_mem[perm[i]] = bus.rs_wdata;
                #1;
                check("fill_we", bus.sram_we, 1);
                check("fill_addr", bus.sram_addr, 32'(perm[i]));
                tick();
            end
        end
        bus.rs_wr_en = 1'b0;
    endtask

    task automatic finish_frame(input logic [2:0] exp_err);
        bus.rs_bin_done = 1'b1;
        tick();
        bus.rs_bin_done = 1'b0;
        exp_fc++;
        check("ready_flag", bus.frame_ready, 1);
        check("ready_done", status_done, 1);
        check("ready_count", frame_count, 32'(exp_fc));
        check("ready_err", status_err, 32'(exp_err));
        check("ready_busy", status_busy, 0);
    endtask

    task automatic read_batch(input int n, input bit sweep);
        int k = 0;
        while (k < n) begin
            logic        req;
            logic [31:0] addr;
            logic [31:0] exp;
            req  = ($urandom_range(4) != 0);
            addr = sweep ? 32'(k) : 32'($urandom_range(NB + 15));
            exp  = (addr < NB) ? ref_mem[addr] : 32'd0;
            bus.cons_req  = req;
            bus.cons_addr = addr;
            #1;
            if (req) begin
                check("rd_gnt", bus.cons_gnt, 1);
                check("rd_sram_addr", bus.sram_addr, addr);
                check("rd_no_we", bus.sram_we, 0);
                k++;
            end else begin
                check("rd_idle_gnt", bus.cons_gnt, 0);
            end
            tick();
            check("rd_rvalid", bus.cons_rvalid, 32'(req));
            if (req) check("rd_data", bus.cons_rdata, exp);
        end
        bus.cons_req = 1'b0;
    endtask

    task automatic release_frame(input bit cont);
        bus.cons_release = 1'b1;
        tick();
        bus.cons_release = 1'b0;
        check("rel_ready_low", bus.frame_ready, 0);
        check("rel_pulse", bus.rs_start_bin, 32'(cont));
        check("rel_done_kept", status_done, 1);
        if (cont) begin
            tick();
            check("rel_pulse_gone", bus.rs_start_bin, 0);
        end
    endtask

    initial begin
        int n;
        int a;
        for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
        for (int i = 0; i < NB; i++) ref_mem[i] = '0;
        exp_fc = 0;
        reset = 1'b1;
        cmd_continuous = 1'b0;
        t_start = 1'b0;
        t_abort = 1'b0;
        t_bus.rs_bin_done = 1'b0; t_bus.rs_addr = '0; t_bus.rs_wdata = '0; t_bus.rs_wr_en = 1'b0;
        t_bus.cons_req = 1'b0; t_bus.cons_addr = '0; t_bus.cons_release = 1'b0; t_bus.sram_rdata = '0;
        clear_inputs();
        repeat (3) tick();
        check("rst_busy", status_busy, 0);
        check("rst_done", status_done, 0);
        check("rst_err", status_err, 0);
        check("rst_count", frame_count, 0);
        check("rst_ready", bus.frame_ready, 0);
        check("rst_pulse", bus.rs_start_bin, 0);
        check("rst_we", bus.sram_we, 0);
        check("rst_rvalid", bus.cons_rvalid, 0);
        reset = 1'b0;
        tick();
        bus.cons_req = 1'b1;
        #1;
        check("idle_no_gnt", bus.cons_gnt, 0);
        bus.cons_req = 1'b0;
        tick();

        // Normal frame, full read sweep, stray write and start while READY.
        start_frame();
        fill(-1, 1'b0);
        finish_frame(3'b000);
        read_batch(NB, 1'b1);
        read_batch(40, 1'b0);
        bus.rs_wr_en = 1'b1;
        bus.rs_addr  = 32'd5;
        bus.rs_wdata = 32'hdead_beef;
        #1;
        check("ready_wr_blocked", bus.sram_we, 0);
        tick();
        bus.rs_wr_en = 1'b0;
        check("ready_wr_err", status_err, 32'b010);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("ready_start_ignored", bus.frame_ready, 1);
        check("ready_start_no_pulse", bus.rs_start_bin, 0);
        read_batch(10, 1'b0);
        release_frame(1'b0);
        check("idle_after_rel", status_busy, 0);

        // Short frame with one out-of-range write.
        start_frame();
        fill($urandom_range(NB - 1), 1'b1);
        finish_frame(3'b110);
        read_batch(60, 1'b0);
        release_frame(1'b0);

        // Watchdog on the short-timeout instance.
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check("tmo_kick", t_bus.rs_start_bin, 1);
        n = 0;
        tick();
        while (t_busy && n < 200) begin
            n++;
            tick();
        end
        check("tmo_fill_cycles", n, 64);
        check("tmo_err", t_err, 32'b001);
        check("tmo_not_done", t_done, 0);
        check("tmo_no_ready", t_bus.frame_ready, 0);
        tick();
        check("tmo_err_held", t_err, 32'b001);
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check("tmo_restart_pulse", t_bus.rs_start_bin, 1);
        check("tmo_restart_clr", t_err, 0);
        t_abort = 1'b1;
        tick();
        t_abort = 1'b0;
        check("tmo_abort_idle", t_busy, 0);

        // Continuous mode: three releases, three restarts.
        cmd_continuous = 1'b1;
        start_frame();
        for (int f = 0; f < 3; f++) begin
            fill(-1, 1'b0);
            finish_frame(3'b000);
            read_batch(30, 1'b0);
            release_frame(1'b1);
        end
        check("cont_count", frame_count, 32'(exp_fc));

        // Abort beats bin_done.
        fill(-1, 1'b0);
        cmd_abort = 1'b1;
        bus.rs_bin_done = 1'b1;
        tick();
        clear_inputs();
        check("abort_done_ready", bus.frame_ready, 0);
        check("abort_done_busy", status_busy, 0);
        check("abort_done_count", frame_count, 32'(exp_fc));
        check("abort_done_clr", status_done, 0);

        // Abort beats release in continuous mode; the in-flight read still returns.
        start_frame();
        fill(-1, 1'b0);
        finish_frame(3'b000);
        a = $urandom_range(NB - 1);
        bus.cons_req = 1'b1;
        bus.cons_addr = 32'(a);
        bus.cons_release = 1'b1;
        cmd_abort = 1'b1;
        #1;
        check("abort_rel_gnt", bus.cons_gnt, 1);
        tick();
        clear_inputs();
        check("abort_rel_ready", bus.frame_ready, 0);
        check("abort_rel_no_pulse", bus.rs_start_bin, 0);
        check("abort_rel_busy", status_busy, 0);
        check("abort_rel_done", status_done, 0);
        check("abort_rel_rvalid", bus.cons_rvalid, 1);
        check("abort_rel_rdata", bus.cons_rdata, ref_mem[a]);
        tick();
        check("abort_rel_rvalid_end", bus.cons_rvalid, 0);

        // Asynchronous reset in the middle of FILL.
        cmd_continuous = 1'b0;
        start_frame();
        for (int i = 0; i < 10; i++) begin
            bus.rs_wr_en = 1'b1;
            bus.rs_addr  = 32'(i);
            bus.rs_wdata = $urandom;
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", status_busy, 0);
        check("arst_done", status_done, 0);
        check("arst_err", status_err, 0);
        check("arst_count", frame_count, 0);
        check("arst_we", bus.sram_we, 0);
        check("arst_addr", bus.sram_addr, 0);
        check("arst_wdata", bus.sram_wdata, 0);
        check("arst_pulse", bus.rs_start_bin, 0);
        check("arst_ready", bus.frame_ready, 0);
        check("arst_rvalid", bus.cons_rvalid, 0);
        check("arst_rdata", bus.cons_rdata, 0);
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_count", frame_count, 0);
        check("post_rst_err", status_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/resize_frame_ctrl.md
# resize_frame_ctrl

Frame-level sequencer and SRAM-port arbiter for the 640x480 → 28x28 grayscale resizer. It kicks the resizer once per frame and routes the resizer's bin writes to the single-port bin SRAM while a frame is filling. It then hands the same SRAM port to the downstream classifier for reading. It reports per-frame status, including timeout, out-of-range and short-frame errors, to the host CPU.

## Interface
- NUM_BINS, 784, words per frame in the bin SRAM (addresses 0..NUM_BINS-1)
- DATA_W, 32, SRAM data width
- TIMEOUT_CYCLES, 1048576, maximum FILL duration in clk cycles
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  host pulse: start a frame (also clears errors)
- cmd_abort  in  1  host pulse: abandon current frame
- cmd_continuous  in  1  level: auto-restart after consumer release
- status_busy  out  1  high in KICK/FILL
- status_done  out  1  sticky: set on entering READY, cleared by cmd_start/abort
- status_err  out  3  sticky: [0] timeout, [1] out-of-range write, [2] short frame
- frame_count  out  16  frames completed, wraps 0xFFFF→0
- rs_start_bin  out  1  one-cycle start pulse to resizer
- rs_bin_done  in  1  resizer completion
- rs_addr  in  32  resizer write address
- rs_wdata  in  DATA_W  resizer write data
- rs_wr_en  in  1  resizer write strobe
- cons_req  in  1  consumer read request
- cons_addr  in  32  consumer read address
- cons_gnt  out  1  read accepted this cycle
- cons_rdata  out  DATA_W  read data
- cons_rvalid  out  1  cons_rdata valid
- cons_release  in  1  consumer pulse: frame fully consumed
- frame_ready  out  1  high in READY
- sram_addr  out  32  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_we  out  1  SRAM write enable
- sram_rdata  in  DATA_W  SRAM read data, 1-cycle latency

## Operation
- States: IDLE, KICK, FILL, READY, ERR.
- IDLE: cmd_start → KICK; clear status_done and status_err, and zero the write counter.
- KICK: rs_start_bin=1 for exactly this cycle → FILL; clear the timeout counter.
- FILL: resizer owns the SRAM.
  - sram_we = rs_wr_en && rs_addr < NUM_BINS; sram_addr and sram_wdata pass through.
  - rs_wr_en with rs_addr ≥ NUM_BINS: write dropped, err[1] set.
  - Each accepted write increments the 11-bit write counter.
  - rs_bin_done → READY. Set err[2] if the write counter ≠ NUM_BINS; the transition still happens.
  - Timeout counter reaches TIMEOUT_CYCLES-1 without rs_bin_done → ERR, err[0] set.
- READY: consumer owns the SRAM.
  - cons_gnt = cons_req, combinational; sram_addr = cons_addr; sram_we = 0.
  - cons_rvalid is asserted the cycle after cons_gnt, with cons_rdata = sram_rdata.
  - If cons_addr ≥ NUM_BINS, the read is granted but cons_rdata is forced to 0.
  - Entering READY sets status_done and increments frame_count.
  - cons_release → KICK if cmd_continuous, else IDLE.
- ERR: holds; status_err is retained. cmd_start → KICK (clears errors); cmd_abort → IDLE.
- Any rs_wr_en outside FILL: ignored, err[1] set. cons_req outside READY: cons_gnt=0.
- cmd_abort in any non-IDLE state → IDLE next cycle; status_done cleared, frame_count unchanged. A pending cons_rvalid still completes.
- cmd_start outside IDLE/ERR is ignored.
- Priority when simultaneous: cmd_abort > rs_bin_done > timeout; cmd_abort > cons_release; cmd_abort > cmd_start.

## Timing
- Reset values: every output 0, state IDLE, counters 0.
- Reset mid-frame clears everything asynchronously. The SRAM contents are undefined and are not cleared.
- cmd_start at cycle n → rs_start_bin at n+1 → FILL from n+2.
- rs_bin_done at cycle m → frame_ready at m+1.
- Read grant to data: 1 cycle. Reads are fully pipelined, one per cycle.
- cons_release at cycle r → frame_ready low at r+1; in continuous mode rs_start_bin at r+1.
- The SRAM port mux is combinational from state; no write and read ever coexist.

## Structure
- Shared package: state encoding enum, NUM_BINS, DATA_W, TIMEOUT_CYCLES default, status_err bit indices.
- Sub-module: bin_port_mux. A purely combinational SRAM owner mux with range checks, selected by a resizer-owns/consumer-owns signal from the FSM.
- The FSM, counters and rvalid pipeline register live in the top level.

## Test plan
- Normal frame: cmd_start; model resizer writes addresses 0..783 with data = addr, then rs_bin_done → one rs_start_bin pulse, frame_ready, frame_count=1, status_err=0, 784 reads return data = addr with 1-cycle latency.
- Timeout: TIMEOUT_CYCLES=64, cmd_start, no rs_bin_done → ERR after 64 FILL cycles, status_err=3'b001; cmd_start → KICK, errors cleared.
- Range/short: write to address 800 plus only 783 valid writes → sram_we low for addr 800, status_err=3'b110 in READY.
- Continuous: cmd_continuous=1, three release cycles → three rs_start_bin pulses, frame_count=3, status_done stays set.
- Abort collisions: cmd_abort with rs_bin_done in the same cycle → IDLE, frame_count unchanged; cmd_abort with cons_release → IDLE even in continuous mode.
- Arbitration: cons_req during FILL → cons_gnt=0; rs_wr_en during READY → sram_we=0, err[1] set; async reset mid-FILL → all outputs 0 the same cycle.
